// File: rtl/ahhre_mult_pipe_if.sv
// Operand/result stream bundle for the AHHRE approximate multiplier pipeline.
// master = producer/consumer side, slave = multiplier side.
// Ports: in_valid/in_ready/x/y/approx_en (request), out_valid/out_ready/p_out/out_approx (result).
interface ahhre_mult_pipe_if #(
  parameter int WIDTH = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic               approx_en;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] p_out;
  logic               out_approx;

  modport master (
    output in_valid, x, y, approx_en, out_ready,
    input  in_ready, out_valid, p_out, out_approx
  );

  modport slave (
    input  in_valid, x, y, approx_en, out_ready,
    output in_ready, out_valid, p_out, out_approx
  );
endinterface

// File: rtl/ahhre_mult_pipe.sv
// Pipelined signed approximate multiplier: low APPROX_BITS digit of y rounded to a signed
// power of two (when approx_en), upper digits exact radix-4 Booth.
// Latency LATENCY cycles accept->out_valid; one result per cycle when unstalled.
// Backpressure: out_valid && !out_ready freezes every stage; in_ready = !stall.
// Ports: clk, rst_n (synchronous, active low), bus (ahhre_mult_pipe_if.slave).
module ahhre_mult_pipe #(
  parameter int WIDTH       = 16,
  parameter int APPROX_BITS = 10,
  parameter int LATENCY     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ahhre_mult_pipe_if.slave     bus
);

  localparam int K    = APPROX_BITS;
  localparam int PW   = 2 * WIDTH;
  localparam int NDIG = (WIDTH - K) / 2;
  // Result register stages after the compute logic. With LATENCY=1 the compute
  // logic sits directly on the inputs and feeds the single output register.
  localparam int R    = (LATENCY == 1) ? 1 : LATENCY - 1;

  // Rounds magnitude m to the nearest power of two, ties upward.
  // m - 2^p >= 2^(p-1) is exactly "bit p-1 set" below the leading one.
  function automatic logic [K-1:0] round_pow2(input logic [K-1:0] m);
    logic [K-1:0] r;
    int           p;
    logic         up;
    p  = 0;
    up = 1'b0;
    r  = '0;
    for (int i = 1; i < K; i++) begin
      if (m[i]) begin
        p  = i;
        up = m[i-1];
      end
    end
    if (m != '0) begin
      r = {{(K-1){1'b0}}, 1'b1} << (up ? p + 1 : p);
    end
    return r;
  endfunction

  logic                 en;
  logic                 op_vld;
  logic [WIDTH-1:0]     op_x;
  logic [WIDTH-1:0]     op_y;
  logic                 op_ae;

  logic [R-1:0]         res_vld;
  logic [R-1:0]         res_a;
  logic [PW-1:0]        res_p [R];

  assign en            = !(res_vld[R-1] && !bus.out_ready);
  assign bus.in_ready  = en;
  assign bus.out_valid = res_vld[R-1];
  assign bus.p_out     = res_p[R-1];
  assign bus.out_approx = res_a[R-1];

  // Stage 1: operand register (absent when LATENCY=1).
  generate
    if (LATENCY == 1) begin : g_no_op_reg
      assign op_vld = bus.in_valid;
      assign op_x   = bus.x;
      assign op_y   = bus.y;
      assign op_ae  = bus.approx_en;
    end else begin : g_op_reg
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          op_vld <= 1'b0;
          op_x   <= '0;
          op_y   <= '0;
          op_ae  <= 1'b0;
        end else if (en) begin
          op_vld <= bus.in_valid;
          if (bus.in_valid) begin
            op_x  <= bus.x;
            op_y  <= bus.y;
            op_ae <= bus.approx_en;
          end
        end
      end
    end
  endgenerate

  // Compute: y = yh*2^K + d0. The low digit d0 is either kept (exact) or
  // replaced by its power-of-two rounding; yh*x is formed by Booth digits
  // whose lowest group borrows y[K-1], which folds the +y[K-1] into yh.
  logic                 d0_neg;
  logic [K-1:0]         d0_mag;
  logic [K-1:0]         rnd_mag;
  logic [K:0]           d0_ext;
  logic [K:0]           d0_rnd;
  logic [K:0]           d_sel;
  logic                 altered;
  logic signed [PW-1:0] xe;
  logic signed [PW-1:0] de;
  logic signed [PW-1:0] low_prod;
  logic signed [PW-1:0] hi_prod;
  logic signed [PW-1:0] pp;
  logic [2:0]           grp;
  logic [PW-1:0]        prod;

  always_comb begin
    d0_neg  = op_y[K-1];
    d0_ext  = {op_y[K-1], op_y[K-1:0]};
    d0_mag  = d0_neg ? (~op_y[K-1:0] + {{(K-1){1'b0}}, 1'b1}) : op_y[K-1:0];
    rnd_mag = round_pow2(d0_mag);
    d0_rnd  = d0_neg ? (~{1'b0, rnd_mag} + {{K{1'b0}}, 1'b1}) : {1'b0, rnd_mag};
    altered = op_ae && (d0_rnd != d0_ext);
    d_sel   = op_ae ? d0_rnd : d0_ext;

    xe       = {{WIDTH{op_x[WIDTH-1]}}, op_x};
    de       = {{(PW-K-1){d_sel[K]}}, d_sel};
    low_prod = xe * de;

    hi_prod = '0;
    pp      = '0;
    grp     = '0;
    for (int j = 0; j < NDIG; j++) begin
      grp = op_y[K+2*j+1 -: 3];
      case (grp)
        3'b001, 3'b010: pp = xe;
        3'b011:         pp = xe <<< 1;
        3'b100:         pp = -(xe <<< 1);
        3'b101, 3'b110: pp = -xe;
        default:        pp = '0;
      endcase
      hi_prod = hi_prod + (pp <<< (K + 2 * j));
    end

    // Wraparound is harmless: every legal result fits in PW bits signed.
    prod = low_prod + hi_prod;
  end

  // Result stages; the last one drives p_out/out_approx.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_vld <= '0;
      res_a   <= '0;
      for (int i = 0; i < R; i++) begin
        res_p[i] <= '0;
      end
    end else if (en) begin
      res_vld[0] <= op_vld;
      if (op_vld) begin
        res_p[0] <= prod;
        res_a[0] <= altered;
      end
      for (int i = 1; i < R; i++) begin
        res_vld[i] <= res_vld[i-1];
        if (res_vld[i-1]) begin
          res_p[i] <= res_p[i-1];
          res_a[i] <= res_a[i-1];
        end
      end
    end
  end

endmodule
